// File: rtl/bit_packer.sv
// -----------------------------------------------------------------------------
// bit_packer
//   Packs a serial bit stream LSB-first into WIDTH-bit words and presents the
//   completed words through a 2-entry FIFO with a valid/ready handshake.
//
//   Parameters
//     WIDTH      bits per output word (legal range 2..32)
//
//   Ports
//     clk        clock, all state updates on rising edge
//     rst        asynchronous active-low reset
//     in_bit     serial data bit
//     in_valid   qualifies in_bit
//     in_ready   block accepts in_bit this cycle (registered state only)
//     flush      discard the partial word (and any bit taken this cycle)
//     out_word   head-of-queue word (0 while the queue is empty)
//     out_valid  out_word holds a valid word
//     out_ready  consumer takes out_word this cycle
//     fill       number of bits held in the partial word
//     out_parity XOR of out_word, stored per entry (BIT_PACKER_PARITY_EN only)
//
//   Build option
//     BIT_PACKER_PARITY_EN  adds out_parity and its per-entry storage
// -----------------------------------------------------------------------------
module bit_packer #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_bit,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       flush,
   output logic [WIDTH-1:0]           out_word,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIDTH+1)-1:0] fill
`ifdef BIT_PACKER_PARITY_EN
   ,
   output logic                       out_parity
`endif
);

   localparam int FW = $clog2(WIDTH+1);
   localparam logic [FW-1:0] LAST = FW'(WIDTH-1);

   logic [FW-1:0]    fill_q, fill_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       cnt_q, cnt_d;
   logic             in_xfer, out_xfer, take, push;
`ifdef BIT_PACKER_PARITY_EN
   logic             par_q [2];
`endif

   // in_ready depends only on registered state: the only stall case is a
   // completing bit with no room in the queue. A pop in the same cycle
   // would free a slot, but honouring it would create an out_ready->in_ready
   // combinational path, so the bit waits one cycle instead.
   assign in_ready  = !((fill_q == LAST) && (cnt_q == 2'd2));
   assign out_valid = (cnt_q != 2'd0);
   assign out_word  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign fill      = fill_q;
`ifdef BIT_PACKER_PARITY_EN
   assign out_parity = out_valid ? par_q[rd_ptr_q] : 1'b0;
`endif

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   // A bit transferred while flush is high is dropped.
   assign take     = in_xfer & ~flush;
   assign push     = take & (fill_q == LAST);

   always_comb begin
      // Stale bits above fill_q are harmless: every position is rewritten
      // before the word completes.
      acc_d = acc_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (fill_q == FW'(i)) acc_d[i] = in_bit;
      end

      fill_d = fill_q;
      if (flush)     fill_d = '0;
      else if (take) fill_d = push ? '0 : fill_q + 1'b1;

      // push with a full queue cannot occur (in_ready is low then)
      unique case ({push, out_xfer})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fill_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
`ifdef BIT_PACKER_PARITY_EN
         par_q[0] <= 1'b0;
         par_q[1] <= 1'b0;
`endif
      end else begin
         fill_q <= fill_d;
         cnt_q  <= cnt_d;
         if (take) acc_q <= acc_d;
         if (push) begin
            mem_q[wr_ptr_q] <= acc_d;
`ifdef BIT_PACKER_PARITY_EN
            par_q[wr_ptr_q] <= ^acc_d;
`endif
            wr_ptr_q <= ~wr_ptr_q;
         end
         if (out_xfer) rd_ptr_q <= ~rd_ptr_q;
      end
   end

endmodule

// File: tb/tb_bit_packer.sv
// -----------------------------------------------------------------------------
// tb_bit_packer
//   Directed and randomized checks of bit_packer (WIDTH = 8) against a
//   queue-based reference model held in the bench.
// -----------------------------------------------------------------------------
module tb_bit_packer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_bit = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid;
   logic [W-1:0] out_word;
   logic [3:0]   fill;
`ifdef BIT_PACKER_PARITY_EN
   logic         out_parity;
`endif

   bit_packer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fill      (fill)
`ifdef BIT_PACKER_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: completed words queue, partial word as count + bits
   bit [W-1:0] mq[$];
   int         mfill = 0;
   bit [W-1:0] mpart = '0;
   int         pushes = 0;
   int         pops = 0;
   int         dut_pops = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_in_ready();
      return !(mfill == W-1 && mq.size() == 2);
   endfunction

   task automatic model_reset();
      mq.delete();
      mfill = 0;
      mpart = '0;
   endtask

   task automatic compare_all();
      logic [W-1:0] head;
      head = (mq.size() != 0) ? mq[0] : '0;
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_word",  32'(out_word),  32'(head));
      chk("in_ready",  32'(in_ready),  32'(m_in_ready()));
      chk("fill",      32'(fill),      32'(mfill));
`ifdef BIT_PACKER_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(^head));
`endif
   endtask

   // Called just after a falling edge: drive, compare, advance model, one cycle.
   task automatic step(input logic iv, input logic ib, input logic fl, input logic ordy);
      bit acc;
      in_valid  = iv;
      in_bit    = ib;
      flush     = fl;
      out_ready = ordy;
      compare_all();
      if (out_valid && ordy) dut_pops++;
      acc = iv && m_in_ready();
      if (mq.size() != 0 && ordy) begin
         void'(mq.pop_front());
         pops++;
      end
      if (fl) begin
         mfill = 0;
         mpart = '0;
      end else if (acc) begin
         mpart[mfill] = ib;
         mfill++;
         if (mfill == W) begin
            mq.push_back(mpart);
            pushes++;
            mfill = 0;
            mpart = '0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bit [W-1:0] pat;
      bit [W-1:0] w1;
      bit [W-1:0] w2;
      int         cyc;

      // reset state, asynchronously while rst is low
      #2;
      chk("rst_fill",      32'(fill),      32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_word",  32'(out_word),  32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      @(negedge clk);
      rst = 1'b1;

      // bits 1,0,1,1,0,0,1,0 -> 8'h4D, valid for one cycle with out_ready high
      pat = 8'b0100_1101;
      for (int i = 0; i < W; i++) step(1'b1, pat[i], 1'b0, 1'b1);
      chk("4d_word",  32'(out_word),  32'h4D);
      chk("4d_valid", 32'(out_valid), 32'd1);
`ifdef BIT_PACKER_PARITY_EN
      chk("4d_parity", 32'(out_parity), 32'd0);
`endif
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("4d_one_cycle", 32'(out_valid), 32'd0);

      // alternating bits with out_ready low: two 8'hAA queued, stall at fill 7
      for (int i = 0; i < 23; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b0);
      chk("aa_stall_ready", 32'(in_ready), 32'd0);
      chk("aa_stall_fill",  32'(fill),     32'd7);
      chk("aa_head",        32'(out_word), 32'hAA);
      step(1'b1, 1'b1, 1'b0, 1'b1);   // 24th bit refused, one word popped
      chk("aa_ready_back", 32'(in_ready), 32'd1);
      chk("aa_fill_held",  32'(fill),     32'd7);
      step(1'b1, 1'b1, 1'b0, 1'b1);   // 24th bit accepted, third word pushed
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("aa_drained", 32'(out_valid), 32'd0);
      chk("aa_ready",   32'(in_ready),  32'd1);

      // 5 bits, then flush with in_valid high, then eight ones
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("flush_fill", 32'(fill), 32'd0);
      for (int i = 0; i < W; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("flush_ff", 32'(out_word), 32'hFF);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // reset mid-word (fill 3) with one word queued
      for (int i = 0; i < W + 3; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
      chk("pre_rst_fill",  32'(fill),      32'd3);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_fill",  32'(fill),      32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_word",  32'(out_word),  32'd0);
      chk("mid_rst_ready", 32'(in_ready),  32'd1);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("post_rst_fill",  32'(fill),      32'd1);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b1);   // clear partial word

      // one queued word, pop and completing push on the same edge
      w1 = 8'hC3;
      w2 = 8'h3C;
      for (int i = 0; i < W; i++) step(1'b1, w1[i], 1'b0, 1'b0);
      for (int i = 0; i < W-1; i++) step(1'b1, w2[i], 1'b0, 1'b0);
      step(1'b1, w2[W-1], 1'b0, 1'b1);
      chk("pp_valid", 32'(out_valid), 32'd1);
      chk("pp_word",  32'(out_word),  32'h3C);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("pp_single", 32'(out_valid), 32'd0);

      // random traffic: 100 words against the model, bounded
      pushes = 0;
      pops = 0;
      dut_pops = 0;
      cyc = 0;
      while (pushes < 100 && cyc < 5000) begin
         step(1'($urandom_range(99) < 80), 1'($urandom_range(1)),
              1'($urandom_range(99) < 3), 1'($urandom_range(99) < 60));
         cyc++;
      end
      chk("rand_budget", 32'(pushes >= 100), 32'd1);
      cyc = 0;
      while (mq.size() != 0 && cyc < 20) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         cyc++;
      end
      chk("rand_empty", 32'(out_valid), 32'd0);
      chk("rand_pops",  32'(dut_pops),  32'(pushes));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of serial bits packed per output word (legal range 2..32).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_bit  input  1  SHALL carry the serial data bit, e.g. the registered feedback output of the upstream looped-NAND stage.
REQ-005 in_valid  input  1  SHALL qualify in_bit.
REQ-006 in_ready  output  1  SHALL indicate the block accepts in_bit this cycle.
REQ-007 flush  input  1  SHALL discard the partially assembled word when high.
REQ-008 out_word  output  WIDTH  SHALL carry the head-of-queue word.
REQ-009 out_valid  output  1  SHALL indicate out_word holds a valid word.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes out_word this cycle.
REQ-011 fill  output  $clog2(WIDTH+1)  SHALL report the bits held in the partial word.

Function
REQ-012 An input transfer SHALL occur on a rising edge when in_valid and in_ready are both high; an output transfer when out_valid and out_ready are both high.
REQ-013 Accepted bits SHALL be packed LSB-first: the first bit after an empty partial word lands in out_word[0], the WIDTH-th in out_word[WIDTH-1].
REQ-014 On the transfer that brings fill to WIDTH, the completed word SHALL be pushed into a 2-entry output queue and fill SHALL return to 0 in the same edge.
REQ-015 out_valid SHALL rise on the edge after the completing transfer (latency 1 cycle from last bit to out_valid).
REQ-016 Queue SHALL be FIFO ordered; out_word SHALL be stable while out_valid high and out_ready low.
REQ-017 in_ready SHALL be low only when fill == WIDTH-1 and the queue holds 2 words; it SHALL be a function of registered state only (no out_ready combinational path).
REQ-018 Simultaneous push and pop with 1 queue entry SHALL leave 1 entry, holding the new word.
REQ-019 flush high SHALL clear fill to 0 on the next edge; a bit transferred in the same cycle SHALL be discarded; queued words SHALL be unaffected.
REQ-020 Flush SHALL NOT block output transfers in the same cycle.
REQ-021 Queue pointers SHALL wrap modulo 2 without loss or duplication.

Reset
REQ-022 While rst is low: fill = 0, queue empty, out_valid = 0, out_word = 0, in_ready = 1, asynchronously.
REQ-023 Reset asserted mid-word or with a full queue SHALL discard all partial and queued data; the first edge after deassertion SHALL be able to accept a bit.

Configuration
REQ-024 With BIT_PACKER_PARITY_EN defined, an output out_parity (1 bit) SHALL exist, equal to the even parity (XOR) of out_word, stored per queue entry; reset value 0.
REQ-025 Without BIT_PACKER_PARITY_EN, port out_parity and its storage SHALL be absent; all other behaviour identical.

Verification (WIDTH = 8)
REQ-026 Bits 1,0,1,1,0,0,1,0 on consecutive cycles, out_ready high -> one cycle after 8th bit out_word = 8'h4D, out_valid high 1 cycle; out_parity = 0 when enabled.
REQ-027 out_ready low, 24 bits of alternating 0,1 -> two words 8'hAA queued; in_ready drops with fill = 7; raise out_ready -> both words drained in order, in_ready returns high.
REQ-028 5 bits then flush with in_valid high -> fill = 0 next edge, flushed bit discarded; next 8 bits all 1 -> out_word = 8'hFF.
REQ-029 rst pulsed low mid-word (fill = 3) with 1 queued word -> out_valid = 0, fill = 0 immediately, no stale word after release.
REQ-030 Queue holding 1 word, out_ready high, 8th bit of next word completes same cycle -> exactly 1 entry remains, containing the new word; no word lost or duplicated over 100 random words vs. a reference model.
